// File: rtl/spm_rmw_pipe_adapter.sv
// spm_rmw_pipe_adapter: turns strobed SPM writes into read-merge-write for a macro without byte
// enables; reads and full-word writes pass straight through with up to MaxOutstanding reads in flight.
module spm_rmw_pipe_adapter #(
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int StrbWidth      = DataWidth / 8,
    parameter int MaxOutstanding = 4,
    parameter bit BypassFullStrb = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic [AddrWidth-1:0] mem_addr_i,
    input  logic [DataWidth-1:0] mem_wdata_i,
    input  logic [StrbWidth-1:0] mem_strb_i,
    input  logic                 mem_we_i,
    output logic                 mem_rvalid_o,
    output logic [DataWidth-1:0] mem_rdata_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic                 mem_we_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 busy_o
);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d, addr_c;
    logic [DataWidth-1:0] wdata_q, wdata_d, wreg_q, wreg_d, wdata_c, merged;
    logic [StrbWidth-1:0] strb_q, strb_d;
    logic                 cnt_ok, passw, nullw, own_rsp, rd_hs;
    logic                 valid_c, ready_c, we_c;

    assign cnt_ok  = cnt_q < CntWidth'(MaxOutstanding);
    assign passw   = mem_we_i & (&mem_strb_i) & BypassFullStrb;
    assign nullw   = mem_we_i & ~(|mem_strb_i);
    // With one read left in flight while waiting, the next response is the RMW read itself.
    assign own_rsp = (state_q == RD_WAIT) && (cnt_q == CntWidth'(1));
    assign rd_hs   = valid_c & mem_ready_i & ~we_c;
    assign cnt_d   = cnt_q + CntWidth'(rd_hs) - CntWidth'(mem_rvalid_i);

    always_comb begin
        merged = '0;
        for (int i = 0; i < StrbWidth; i++)
            merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : mem_rdata_i[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        wreg_d  = wreg_q;
        valid_c = 1'b0;
        ready_c = 1'b0;
        we_c    = 1'b0;
        addr_c  = addr_q;
        wdata_c = wreg_q;
        case (state_q)
            IDLE: begin
                addr_c  = mem_addr_i;
                wdata_c = mem_wdata_i;
                we_c    = mem_we_i;
                if (!mem_we_i) begin
                    valid_c = mem_valid_i & cnt_ok;
                    ready_c = mem_ready_i & cnt_ok;
                end else if (passw) begin
                    valid_c = mem_valid_i;
                    ready_c = mem_ready_i;
                end else if (nullw) begin
                    ready_c = 1'b1;
                end else begin
                    ready_c = cnt_ok;
                    if (mem_valid_i && cnt_ok) begin
                        addr_d  = mem_addr_i;
                        wdata_d = mem_wdata_i;
                        strb_d  = mem_strb_i;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                valid_c = 1'b1;
                if (mem_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid_i && own_rsp) begin
                    wreg_d  = merged;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                valid_c = 1'b1;
                we_c    = 1'b1;
                if (mem_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            wreg_q  <= wreg_d;
        end
    end

    // Outputs are forced quiet for the whole reset pulse, not just after the next edge.
    assign mem_ready_o  = ~rst_i & ready_c;
    assign mem_valid_o  = ~rst_i & valid_c;
    assign mem_we_o     = ~rst_i & we_c;
    assign mem_addr_o   = rst_i ? '0 : addr_c;
    assign mem_wdata_o  = rst_i ? '0 : wdata_c;
    assign mem_rvalid_o = ~rst_i & mem_rvalid_i & ~own_rsp;
    assign mem_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign busy_o       = state_q != IDLE;

    rsp_without_read: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> cnt_q != '0);
endmodule
